data_memory_dma: RTL and testbench
==================================

# data_memory_dma

Block-transfer initiator on the data-memory port: it copies or fills a range of the 1024 x 8 data memory without CPU involvement. It sits between the control unit and `data_memory`, sharing that memory's `in_addr`/`in_write_en`/`in_data`/`out_data` port through the top-level arbiter. It drives addresses, write enable and write data, and consumes read data. Ranges touching the IO ports at 0x3FE/0x3FF are rejected, never accessed.

## Interface
- ADDR_WIDTH, 10, memory address width
- DATA_WIDTH, 8, memory data width
- IO_BASE, 10'h3FE, first IO-port address; valid transfer range is 0 .. IO_BASE-1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_start  in  1  command strobe, sampled in IDLE only
- in_mode  in  1  0 = copy, 1 = fill (fill requires DATA_MEMORY_DMA_FILL_EN)
- in_src_addr  in  ADDR_WIDTH  copy source base
- in_dst_addr  in  ADDR_WIDTH  destination base
- in_len  in  ADDR_WIDTH  byte count, 0 = no-op
- in_fill_data  in  DATA_WIDTH  fill byte
- in_mem_data  in  DATA_WIDTH  memory read data (memory `out_data`)
- out_mem_addr  out  ADDR_WIDTH  memory address
- out_mem_write_en  out  1  memory write enable
- out_mem_data  out  DATA_WIDTH  memory write data
- out_busy  out  1  transfer in progress
- out_done  out  1  one-cycle completion pulse
- out_error  out  1  one-cycle pulse with out_done when the command was rejected

## Operation
- FSM states: IDLE, CHECK, RD, WR, DONE.
- IDLE: in_start=1 at an edge latches src, dst, len, mode, fill byte; go CHECK. in_start in any other state is ignored.
- CHECK (1 cycle, busy=1): 11-bit end = base + len - 1 for dst (and src in copy mode). If len==0 -> DONE with error=0. If any end >= IO_BASE, or fill mode with macro off -> DONE with error=1. Otherwise copy -> RD, fill -> WR.
- RD: out_mem_addr = src pointer, write_en=0; go WR.
- WR: out_mem_addr = dst pointer, write_en=1, out_mem_data = in_mem_data (copy) or latched fill byte (fill). Decrement remaining count; increment pointers. Remaining > 0 -> RD (copy) / WR (fill); else DONE.
- DONE (1 cycle): out_done=1, out_error per CHECK result, busy=0; go IDLE.
- Order strictly ascending addresses; overlapping copies with dst > src replicate source bytes (defined behaviour, no overlap correction).
- Pointers never wrap: CHECK guarantees end < IO_BASE.
- Outside WR, write_en=0 and out_mem_data=0.

## Timing
- Memory read is synchronous: address presented in RD appears on in_mem_data in the following WR cycle.
- in_start at edge E0 -> out_busy=1 from cycle after E0 (CHECK).
- Copy of N bytes: busy for 1 + 2N cycles; fill: 1 + N cycles; rejected/zero-length: 1 cycle. DONE follows immediately; out_done high exactly one cycle with busy=0.
- Earliest new command: in_start sampled at the edge ending DONE is ignored; accepted at the following edge in IDLE.
- Reset values: out_mem_addr=0, out_mem_write_en=0, out_mem_data=0, out_busy=0, out_done=0, out_error=0; FSM=IDLE.
- rst_n low mid-transfer clears all outputs immediately (asynchronously), aborts without out_done; bytes already written remain.

## Configuration
- DATA_MEMORY_DMA_FILL_EN defined: in_mode=1 performs fill, one byte per cycle.
- Not defined: fill datapath and fill-byte register removed; in_mode=1 is rejected in CHECK (out_done=1, out_error=1, no memory access).

## Test plan
- Preload 0x001..0x003 = 0x02,0x04,0x08; copy src=0x001 dst=0x010 len=3 -> busy 7 cycles, done pulse, memory 0x010..0x012 = 0x02,0x04,0x08, no write outside.
- Fill (macro on) dst=0x100 len=4 data=0xA5 -> busy 5 cycles, 0x100..0x103 = 0xA5; macro off -> done+error, memory unchanged.
- len=0 -> busy 1 cycle, done=1, error=0, write_en never asserted.
- copy dst=0x3FC len=3 (touches 0x3FE) -> done+error, no write; dst=0x3FB len=3 (ends 0x3FD) -> succeeds.
- Assert rst_n=0 after second write of a len=5 copy -> all outputs 0 same cycle, no done; first two destination bytes written, remainder untouched.
- Pulse in_start with different args while busy -> ignored; original transfer completes with original data.

Source files
------------

// File: rtl/data_memory_dma.sv
// Block-copy / block-fill initiator on the shared data-memory port.
// Optional fill datapath is enabled by defining DATA_MEMORY_DMA_FILL_EN.
//
//   state | meaning
//   IDLE  | waiting for in_start; command fields are latched on the strobe
//   CHECK | range / mode validation, one cycle
//   RD    | present source address (copy only)
//   WR    | write one byte to the destination pointer
//   DONE  | one-cycle completion pulse, error flag if rejected
module data_memory_dma #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 10'h3FE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_start,
    input  logic                  in_mode,
    input  logic [ADDR_WIDTH-1:0] in_src_addr,
    input  logic [ADDR_WIDTH-1:0] in_dst_addr,
    input  logic [ADDR_WIDTH-1:0] in_len,
    input  logic [DATA_WIDTH-1:0] in_fill_data,
    input  logic [DATA_WIDTH-1:0] in_mem_data,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic                  out_mem_write_en,
    output logic [DATA_WIDTH-1:0] out_mem_data,
    output logic                  out_busy,
    output logic                  out_done,
    output logic                  out_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RD,
        S_WR,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  mode_q, mode_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH:0]   src_end, dst_end;
    logic                  range_bad;
    logic                  fill_bad;
    logic [DATA_WIDTH-1:0] wr_data;

`ifdef DATA_MEMORY_DMA_FILL_EN
    logic [DATA_WIDTH-1:0] fill_q, fill_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (state_q == S_IDLE && in_start) begin
            fill_d = in_fill_data;
        end
    end

    assign fill_bad = 1'b0;
    assign wr_data  = mode_q ? fill_q : in_mem_data;
`else
    logic unused_fill;

    assign unused_fill = ^in_fill_data;
    assign fill_bad    = mode_q;
    assign wr_data     = in_mem_data;
`endif

    // 11-bit ends so a range running past the top of memory cannot alias low.
    assign src_end = ({1'b0, src_q} + {1'b0, cnt_q}) - (ADDR_WIDTH+1)'(1);
    assign dst_end = ({1'b0, dst_q} + {1'b0, cnt_q}) - (ADDR_WIDTH+1)'(1);

    assign range_bad = (dst_end >= {1'b0, IO_BASE}) ||
                       (!mode_q && (src_end >= {1'b0, IO_BASE}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        src_d            = src_q;
        dst_d            = dst_q;
        cnt_d            = cnt_q;
        mode_d           = mode_q;
        err_d            = err_q;
        out_mem_addr     = '0;
        out_mem_write_en = 1'b0;
        out_mem_data     = '0;
        out_busy         = 1'b0;
        out_done         = 1'b0;
        out_error        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    src_d   = in_src_addr;
                    dst_d   = in_dst_addr;
                    cnt_d   = in_len;
                    mode_d  = in_mode;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                out_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else if (range_bad || fill_bad) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WR : S_RD;
                end
            end
            S_RD: begin
                out_busy     = 1'b1;
                out_mem_addr = src_q;
                state_d      = S_WR;
            end
            S_WR: begin
                out_busy         = 1'b1;
                out_mem_addr     = dst_q;
                out_mem_write_en = 1'b1;
                out_mem_data     = wr_data;
                cnt_d            = cnt_q - ADDR_WIDTH'(1);
                dst_d            = dst_q + ADDR_WIDTH'(1);
                src_d            = src_q + ADDR_WIDTH'(1);
                if (cnt_q == ADDR_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = mode_q ? S_WR : S_RD;
                end
            end
            S_DONE: begin
                out_done  = 1'b1;
                out_error = err_q;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_memory_dma.sv
// Randomised bench for data_memory_dma: a bench-side memory serves the DUT,
// a byte-level reference predicts every write, busy length and error flag.
module tb_data_memory_dma;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_start = 1'b0;
    logic       in_mode = 1'b0;
    logic [9:0] in_src_addr = '0;
    logic [9:0] in_dst_addr = '0;
    logic [9:0] in_len = '0;
    logic [7:0] in_fill_data = '0;
    logic [7:0] in_mem_data;
    logic [9:0] out_mem_addr;
    logic       out_mem_write_en;
    logic [7:0] out_mem_data;
    logic       out_busy;
    logic       out_done;
    logic       out_error;

    data_memory_dma dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_start         (in_start),
        .in_mode          (in_mode),
        .in_src_addr      (in_src_addr),
        .in_dst_addr      (in_dst_addr),
        .in_len           (in_len),
        .in_fill_data     (in_fill_data),
        .in_mem_data      (in_mem_data),
        .out_mem_addr     (out_mem_addr),
        .out_mem_write_en (out_mem_write_en),
        .out_mem_data     (out_mem_data),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_error        (out_error)
    );

    always #5 clk = ~clk;

`ifdef DATA_MEMORY_DMA_FILL_EN
    localparam bit FILL_OK = 1'b1;
`else
    localparam bit FILL_OK = 1'b0;
`endif

    // Bench memory: synchronous read, read-before-write.
    logic [7:0] tb_mem [1024];
    logic [7:0] ref_mem[1024];
    logic [7:0] rd_q = '0;
    assign in_mem_data = rd_q;

    always @(posedge clk) begin
        rd_q <= tb_mem[out_mem_addr];
        if (out_mem_write_en) tb_mem[out_mem_addr] = out_mem_data;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [9:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    int         exp_busy = 0;
    bit         exp_err = 0;
    bit         exp_pending = 0;
    int         busy_cnt = 0;
    int         done_cnt = 0;
    int         wr_cnt = 0;
    int         last_busy = 0;
    bit         last_err = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_busy) begin
                busy_cnt++;
                chk("busy_expected", 32'(exp_pending), 1);
            end
            if (out_mem_write_en) begin
                chk("we_only_while_busy", 32'(out_busy), 1);
                if (exp_wa.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=%0h/%0h required=none", out_mem_addr, out_mem_data);
                end else begin
                    chk("wr_addr", 32'(out_mem_addr), 32'(exp_wa[0]));
                    chk("wr_data", 32'(out_mem_data), 32'(exp_wd[0]));
                    ref_mem[exp_wa[0]] = exp_wd[0];
                    void'(exp_wa.pop_front());
                    void'(exp_wd.pop_front());
                    wr_cnt++;
                end
            end else begin
                chk("data_zero_outside_wr", 32'(out_mem_data), 0);
            end
            if (out_done) begin
                chk("done_expected", 32'(exp_pending), 1);
                chk("done_busy_low", 32'(out_busy), 0);
                chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
                chk("done_error", 32'(out_error), 32'(exp_err));
                chk("writes_drained", 32'(exp_wa.size()), 0);
                last_busy   = busy_cnt;
                last_err    = out_error;
                exp_pending = 0;
                busy_cnt    = 0;
                done_cnt++;
            end else begin
                chk("error_without_done", 32'(out_error), 0);
            end
        end
    end

    // Reference: byte-by-byte ascending transfer over a scratch image.
    task automatic expect_cmd(input bit mode, input int src, input int dst, input int len, input logic [7:0] fill);
        logic [7:0] scr[1024];
        bit err;
        for (int i = 0; i < 1024; i++) scr[i] = ref_mem[i];
        err = (len != 0) && ((dst + len - 1 >= 'h3FE) ||
                             (!mode && (src + len - 1 >= 'h3FE)) ||
                             (mode && !FILL_OK));
        exp_err  = err;
        exp_busy = (len == 0 || err) ? 1 : (mode ? 1 + len : 1 + 2 * len);
        exp_wa.delete();
        exp_wd.delete();
        if (!err) begin
            for (int i = 0; i < len; i++) begin
                logic [7:0] b;
                b = mode ? fill : scr[src + i];
                scr[dst + i] = b;
                exp_wa.push_back(10'(dst + i));
                exp_wd.push_back(b);
            end
        end
        exp_pending = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_start = 1'b0;
        exp_wa.delete();
        exp_wd.delete();
        exp_pending = 0;
        busy_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input bit mode, input int src, input int dst, input int len,
                         input logic [7:0] fill, input bit poke, input bit hold_in_done);
        int d0;
        bit finished;
        @(negedge clk);
        expect_cmd(mode, src, dst, len, fill);
        in_mode      = mode;
        in_src_addr  = 10'(src);
        in_dst_addr  = 10'(dst);
        in_len       = 10'(len);
        in_fill_data = fill;
        in_start     = 1'b1;
        d0 = done_cnt;
        finished = 0;
        for (int i = 0; i < 2 * len + 10; i++) begin
            @(negedge clk);
            #1;
            if (i == 0) begin
                in_mode      = 1'($urandom);
                in_src_addr  = 10'($urandom);
                in_dst_addr  = 10'($urandom);
                in_len       = 10'($urandom);
                in_fill_data = 8'($urandom);
            end
            if (done_cnt != d0) begin
                finished = 1;
                if (hold_in_done) begin
                    in_len   = '0;
                    in_start = 1'b1;
                    @(negedge clk);
                    #1;
                end
                in_start = 1'b0;
                break;
            end
            in_start = poke && (i == 2);
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no_done required=done len=%0d", len);
            do_reset();
        end
    endtask

    initial begin
        logic [7:0] s0f, s13, s42, s43, s44;
        logic [7:0] sf[4];
        int w0, d0, nmis;

        for (int i = 0; i < 1024; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        tb_mem[1] = 8'h02; tb_mem[2] = 8'h04; tb_mem[3] = 8'h08;
        ref_mem[1] = 8'h02; ref_mem[2] = 8'h04; ref_mem[3] = 8'h08;
        #1;
        chk("rst_addr", 32'(out_mem_addr), 0);
        chk("rst_we", 32'(out_mem_write_en), 0);
        chk("rst_data", 32'(out_mem_data), 0);
        chk("rst_busy", 32'(out_busy), 0);
        chk("rst_done", 32'(out_done), 0);
        chk("rst_error", 32'(out_error), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Three-byte copy.
        s0f = tb_mem[10'h0F];
        s13 = tb_mem[10'h13];
        issue(0, 10'h001, 10'h010, 3, 8'h00, 0, 0);
        chk("copy_busy", 32'(last_busy), 7);
        chk("copy_err", 32'(last_err), 0);
        chk("copy_b0", 32'(tb_mem[10'h10]), 32'h02);
        chk("copy_b1", 32'(tb_mem[10'h11]), 32'h04);
        chk("copy_b2", 32'(tb_mem[10'h12]), 32'h08);
        chk("copy_below", 32'(tb_mem[10'h0F]), 32'(s0f));
        chk("copy_above", 32'(tb_mem[10'h13]), 32'(s13));

        // Fill.
        for (int i = 0; i < 4; i++) sf[i] = tb_mem[10'h100 + i];
        issue(1, 0, 10'h100, 4, 8'hA5, 0, 0);
        if (FILL_OK) begin
            chk("fill_busy", 32'(last_busy), 5);
            chk("fill_err", 32'(last_err), 0);
            for (int i = 0; i < 4; i++) chk("fill_byte", 32'(tb_mem[10'h100 + i]), 32'hA5);
        end else begin
            chk("fill_rej_busy", 32'(last_busy), 1);
            chk("fill_rej_err", 32'(last_err), 1);
            for (int i = 0; i < 4; i++) chk("fill_rej_byte", 32'(tb_mem[10'h100 + i]), 32'(sf[i]));
        end

        // Zero length.
        w0 = wr_cnt;
        issue(0, 10'h005, 10'h200, 0, 8'h00, 0, 0);
        chk("len0_busy", 32'(last_busy), 1);
        chk("len0_err", 32'(last_err), 0);
        chk("len0_writes", 32'(wr_cnt - w0), 0);

        // IO boundary.
        w0 = wr_cnt;
        issue(0, 10'h050, 10'h3FC, 3, 8'h00, 0, 0);
        chk("io_rej_err", 32'(last_err), 1);
        chk("io_rej_writes", 32'(wr_cnt - w0), 0);
        issue(0, 10'h050, 10'h3FB, 3, 8'h00, 0, 0);
        chk("io_edge_err", 32'(last_err), 0);
        chk("io_edge_busy", 32'(last_busy), 7);
        chk("io_edge_b2", 32'(tb_mem[10'h3FD]), 32'(tb_mem[10'h052]));

        // Reset after the second write of a five-byte copy.
        for (int i = 0; i < 5; i++) begin
            tb_mem[10'h020 + i]  = 8'(8'h11 + i);
            ref_mem[10'h020 + i] = 8'(8'h11 + i);
        end
        s42 = tb_mem[10'h042]; s43 = tb_mem[10'h043]; s44 = tb_mem[10'h044];
        @(negedge clk);
        expect_cmd(0, 10'h020, 10'h040, 5, 8'h00);
        in_mode = 0; in_src_addr = 10'h020; in_dst_addr = 10'h040; in_len = 10'd5;
        in_start = 1'b1;
        w0 = wr_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 20 && (wr_cnt - w0) < 2; i++) begin
            @(negedge clk);
            #1;
            in_start = 1'b0;
        end
        chk("rst_mid_two_writes", 32'(wr_cnt - w0), 2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_addr", 32'(out_mem_addr), 0);
        chk("rst_mid_we", 32'(out_mem_write_en), 0);
        chk("rst_mid_data", 32'(out_mem_data), 0);
        chk("rst_mid_busy", 32'(out_busy), 0);
        chk("rst_mid_done", 32'(out_done), 0);
        chk("rst_mid_error", 32'(out_error), 0);
        do_reset();
        repeat (3) @(negedge clk);
        chk("rst_mid_no_done", 32'(done_cnt - d0), 0);
        chk("rst_mid_b0", 32'(tb_mem[10'h040]), 32'h11);
        chk("rst_mid_b1", 32'(tb_mem[10'h041]), 32'h12);
        chk("rst_mid_b2", 32'(tb_mem[10'h042]), 32'(s42));
        chk("rst_mid_b3", 32'(tb_mem[10'h043]), 32'(s43));
        chk("rst_mid_b4", 32'(tb_mem[10'h044]), 32'(s44));

        // Start held through the DONE cycle must be ignored.
        d0 = done_cnt;
        issue(0, 10'h060, 10'h070, 2, 8'h00, 1, 1);
        repeat (4) @(negedge clk);
        chk("start_in_done_ignored", 32'(done_cnt - d0), 1);

        // Randomised commands, some overlapping, some near the IO ports.
        for (int n = 0; n < 60; n++) begin
            int s, d, l;
            bit m;
            m = ($urandom_range(0, 3) == 0);
            l = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
            case ($urandom_range(0, 2))
                0: begin s = $urandom_range(0, 1023); d = $urandom_range(0, 1023); end
                1: begin s = $urandom_range(0, 63); d = s + $urandom_range(0, 8); end
                default: begin s = $urandom_range(960, 1023); d = $urandom_range(980, 1023); end
            endcase
            issue(m, s, d, l, 8'($urandom), 1'($urandom), 1'($urandom));
        end
        repeat (4) @(negedge clk);

        nmis = 0;
        for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) nmis++;
        chk("final_mem_mismatches", 32'(nmis), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
